// File: rtl/hv_frame_parser.sv
// Frame parser for the HV supply serial link: STX, payload, ETX, XOR checksum, CR.
// Holds one checked payload for the consumer and reports framing errors and overruns.
module hv_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned LEN_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              soft_rst_i,
  input  logic [7:0]        din_i,
  input  logic              din_valid_i,
  output logic              frame_valid_o,
  input  logic              frame_ack_i,
  output logic [LEN_W-1:0]  payload_len_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic              frame_err_o,
  output logic [2:0]        err_code_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam logic [7:0] Stx = 8'h02;
  localparam logic [7:0] Etx = 8'h03;
  localparam logic [7:0] Cr  = 8'h0D;

  localparam logic [2:0] ErrOverflow = 3'd1;
  localparam logic [2:0] ErrChecksum = 3'd2;
  localparam logic [2:0] ErrNoCr     = 3'd3;
  localparam logic [2:0] ErrTimeout  = 3'd4;
  localparam logic [2:0] ErrEmpty    = 3'd5;

  localparam int unsigned    BufDepth = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  // Counter value one edge before it would reach TIMEOUT_CYC-1.
  localparam logic [TO_W-1:0]  ToLast = TO_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {StIdle, StPayload, StChk, StTerm} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   count_q;
  logic [7:0]         xor_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic               frame_valid_q;
  logic [LEN_W-1:0]   payload_len_q;
  logic               frame_err_q;
  logic [2:0]         err_code_q;
  logic               overrun_q;
  logic [7:0]         buf_q [BufDepth];

  logic               buf_we;
  logic               timeout_hit;

  assign timeout_hit = (to_cnt_q == ToLast);
  assign buf_we      = (state_q == StPayload) && din_valid_i && (din_i != Etx) &&
                       (count_q < MaxLen) && !soft_rst_i;

  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buf_q[count_q[ADDR_W-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      count_q       <= '0;
      xor_q         <= '0;
      to_cnt_q      <= '0;
      frame_valid_q <= 1'b0;
      payload_len_q <= '0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      overrun_q     <= 1'b0;
    end else if (soft_rst_i) begin
      state_q       <= StIdle;
      count_q       <= '0;
      xor_q         <= '0;
      to_cnt_q      <= '0;
      frame_valid_q <= 1'b0;
      payload_len_q <= '0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      overrun_q     <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (frame_ack_i) begin
        frame_valid_q <= 1'b0;
      end
      if ((state_q == StIdle) || din_valid_i) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (din_valid_i) begin
            // An ack in the same cycle frees the buffer for the incoming STX.
            if (frame_valid_q && !frame_ack_i) begin
              overrun_q <= 1'b1;
            end else if (din_i == Stx) begin
              count_q <= '0;
              xor_q   <= '0;
              state_q <= StPayload;
            end
          end
        end
        StPayload: begin
          if (din_valid_i) begin
            if (din_i == Etx) begin
              if (count_q != '0) begin
                state_q <= StChk;
              end else begin
                frame_err_q <= 1'b1;
                err_code_q  <= ErrEmpty;
                state_q     <= StIdle;
              end
            end else if (count_q == MaxLen) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ErrOverflow;
              state_q     <= StIdle;
            end else begin
              count_q <= count_q + LEN_W'(1);
              xor_q   <= xor_q ^ din_i;
            end
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ErrTimeout;
            state_q     <= StIdle;
          end
        end
        StChk: begin
          if (din_valid_i) begin
            if (din_i == xor_q) begin
              state_q <= StTerm;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ErrChecksum;
              state_q     <= StIdle;
            end
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ErrTimeout;
            state_q     <= StIdle;
          end
        end
        StTerm: begin
          if (din_valid_i) begin
            if (din_i == Cr) begin
              payload_len_q <= count_q;
              frame_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ErrNoCr;
            end
            state_q <= StIdle;
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ErrTimeout;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frame_valid_o = frame_valid_q;
  assign payload_len_o = payload_len_q;
  assign rd_data_o     = buf_q[rd_addr_i];
  assign frame_err_o   = frame_err_q;
  assign err_code_o    = err_code_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_hv_frame_parser.sv
// Bench for hv_frame_parser: a frame-level reference model compared every cycle,
// plus directed frames with literal expectations.
module tb_hv_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TO_CYC  = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_valid;
  logic       frame_ack;
  logic [4:0] payload_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_err;
  logic [2:0] err_code;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  hv_frame_parser #(
    .MAX_LEN    (MAX_LEN),
    .ADDR_W     (4),
    .LEN_W      (5),
    .TIMEOUT_CYC(TO_CYC),
    .TO_W       (17)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .soft_rst_i   (soft_rst),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .frame_valid_o(frame_valid),
    .frame_ack_i  (frame_ack),
    .payload_len_o(payload_len),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .frame_err_o  (frame_err),
    .err_code_o   (err_code),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: keeps the bytes received since STX and judges the frame as a whole.
  bit         m_in;
  logic [7:0] q[$];
  bit         m_fv;
  int         m_len;
  logic [7:0] m_pay[MAX_LEN];
  bit         m_err;
  logic [2:0] m_code;
  bit         m_ovr;
  int         m_quiet;

  task automatic m_reset();
    m_in = 0; m_fv = 0; m_len = 0; m_err = 0; m_code = 0; m_ovr = 0; m_quiet = 0;
    q.delete();
  endtask

  task automatic m_fail(input logic [2:0] c);
    m_err = 1; m_code = c; m_in = 0;
  endtask

  task automatic m_judge();
    int e;
    logic [7:0] x;
    e = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (e < 0 && q[i] == 8'h03) e = i;
    end
    if (e < 0) begin
      if (q.size() > MAX_LEN) m_fail(3'd1);
    end else if (e == 0) begin
      m_fail(3'd5);
    end else if (q.size() == e + 2) begin
      x = 8'h00;
      for (int i = 0; i < e; i++) x = x ^ q[i];
      if (x != q[e+1]) m_fail(3'd2);
    end else if (q.size() == e + 3) begin
      if (q[e+2] == 8'h0d) begin
        m_fv = 1; m_len = e; m_in = 0;
        for (int i = 0; i < e; i++) m_pay[i] = q[i];
      end else begin
        m_fail(3'd3);
      end
    end
  endtask

  task automatic m_step();
    bit fv_before;
    m_err = 0; m_ovr = 0;
    fv_before = m_fv;
    if (soft_rst) begin
      m_reset();
    end else begin
      if (frame_ack) m_fv = 0;
      if (!m_in) begin
        if (din_valid) begin
          if (fv_before && !frame_ack) m_ovr = 1;
          else if (din == 8'h02) begin
            m_in = 1; q.delete(); m_quiet = 0;
          end
        end
      end else if (din_valid) begin
        q.push_back(din); m_quiet = 0;
        m_judge();
      end else begin
        m_quiet++;
        if (m_quiet == TO_CYC - 1) m_fail(3'd4);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (run) begin
      chk("frame_valid", frame_valid, m_fv);
      chk("payload_len", payload_len, m_len);
      chk("frame_err", frame_err, m_err);
      chk("err_code", err_code, m_code);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_in);
      if (m_fv && rd_addr < m_len) chk("rd_data", rd_data, m_pay[rd_addr]);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); din = b; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1 rd_addr = rd_addr + 4'd1;
    end
  endtask

  task automatic ack();
    @(negedge clk); frame_ack = 1'b1;
    @(negedge clk); frame_ack = 1'b0;
    #1 chk("fv after ack", frame_valid, 1'b0);
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1 chk(name, rd_data, exp);
  endtask

  int ovr_cnt;

  initial begin
    rst_n = 1'b1; soft_rst = 1'b0; din = 8'h00; din_valid = 1'b0;
    frame_ack = 1'b0; rd_addr = 4'd0;
    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset fv", frame_valid, 1'b0);
    chk("reset len", payload_len, 5'd0);
    chk("reset err", frame_err, 1'b0);
    chk("reset code", err_code, 3'd0);
    chk("reset busy", busy, 1'b0);

    // Good frame, bytes 20 cycles apart.
    send(8'h02); idle(20); send(8'ha5); idle(20); send(8'h5a); idle(20);
    send(8'h03); idle(20); send(8'hff); idle(20); send(8'h0d);
    #1 chk("good fv", frame_valid, 1'b1);
    chk("good len", payload_len, 5'd2);
    chk("good no err", frame_err, 1'b0);
    read_chk("good rd0", 4'd0, 8'ha5);
    read_chk("good rd1", 4'd1, 8'h5a);
    idle(3);
    ack();

    // Checksum error.
    send(8'h02); send(8'ha5); send(8'h5a); send(8'h03); send(8'h00);
    #1 chk("chk err", frame_err, 1'b1);
    chk("chk code", err_code, 3'd2);
    idle(2);
    chk("chk fv", frame_valid, 1'b0);
    chk("chk busy", busy, 1'b0);

    // Overflow on the 17th data byte.
    send(8'h02);
    for (int i = 0; i < 16; i++) send(8'h11);
    #1 chk("ovf not early", frame_err, 1'b0);
    send(8'h11);
    #1 chk("ovf err", frame_err, 1'b1);
    chk("ovf code", err_code, 3'd1);
    idle(2);

    // Empty frame, then missing CR.
    send(8'h02); send(8'h03);
    #1 chk("empty code", err_code, 3'd5);
    send(8'h02); send(8'ha5); send(8'h03); send(8'ha5); send(8'h0a);
    #1 chk("nocr err", frame_err, 1'b1);
    chk("nocr code", err_code, 3'd3);
    idle(2);

    // Timeout exactly TO_CYC-1 edges after the last byte.
    send(8'h02); send(8'ha5);
    repeat (TO_CYC - 2) @(negedge clk);
    #1 chk("to not early", frame_err, 1'b0);
    @(negedge clk);
    #1 chk("to err", frame_err, 1'b1);
    chk("to code", err_code, 3'd4);
    send(8'h02); send(8'ha5); send(8'h03); send(8'ha5); send(8'h0d);
    #1 chk("after to len", payload_len, 5'd1);
    chk("after to fv", frame_valid, 1'b1);
    ack();

    // Unacked frame, then a second frame is dropped byte by byte.
    send(8'h02); send(8'ha5); send(8'h03); send(8'ha5); send(8'h0d);
    ovr_cnt = 0;
    send(8'h02); #1 if (overrun) ovr_cnt++;
    send(8'h5a); #1 if (overrun) ovr_cnt++;
    send(8'h03); #1 if (overrun) ovr_cnt++;
    send(8'h5a); #1 if (overrun) ovr_cnt++;
    send(8'h0d); #1 if (overrun) ovr_cnt++;
    chk("overrun count", ovr_cnt, 5);
    chk("held fv", frame_valid, 1'b1);
    read_chk("held rd0", 4'd0, 8'ha5);
    // Ack together with a new STX.
    @(negedge clk); frame_ack = 1'b1; din = 8'h02; din_valid = 1'b1;
    @(negedge clk); frame_ack = 1'b0; din_valid = 1'b0;
    #1 chk("ack+stx busy", busy, 1'b1);
    chk("ack+stx fv", frame_valid, 1'b0);
    send(8'h5a); send(8'h03); send(8'h5a); send(8'h0d);
    #1 chk("ack+stx len", payload_len, 5'd1);
    read_chk("ack+stx rd0", 4'd0, 8'h5a);
    ack();

    // Garbage before a frame is ignored.
    send(8'hff); send(8'h0d); send(8'h03);
    #1 chk("garbage busy", busy, 1'b0);
    chk("garbage err", frame_err, 1'b0);
    send(8'h02); send(8'ha5); send(8'h5a); send(8'h03); send(8'hff); send(8'h0d);
    #1 chk("garbage fv", frame_valid, 1'b1);
    ack();

    // Asynchronous reset mid-payload.
    send(8'h02); send(8'ha5);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("arst busy", busy, 1'b0);
    chk("arst code", err_code, 3'd0);
    chk("arst len", payload_len, 5'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Synchronous clear mid-payload.
    send(8'h02); send(8'ha5);
    @(negedge clk); soft_rst = 1'b1;
    #1 chk("srst not yet", busy, 1'b1);
    @(negedge clk); soft_rst = 1'b0;
    #1 chk("srst busy", busy, 1'b0);
    chk("srst err", frame_err, 1'b0);
    send(8'h02); send(8'ha5); send(8'h5a); send(8'h03); send(8'hff); send(8'h0d);
    #1 chk("srst next fv", frame_valid, 1'b1);
    chk("srst next len", payload_len, 5'd2);
    ack();
    idle(3);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
